commit_trace_buf: RTL and testbench

//  Captures per-cycle architectural commit events from the EXU: RF write, JAL/JALR redirect,

---
 rtl/commit_trace_buf_pkg.sv | 36 +++
 rtl/commit_trace_buf_if.sv | 12 +
 rtl/commit_trace_buf_fifo.sv | 47 ++++
 rtl/commit_trace_buf.sv | 117 +++++++++++
 tb/tb_commit_trace_buf.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/commit_trace_buf_pkg.sv
// Shared types and constants for the commit trace buffer: record layout,
// kind-flag bit positions and drain FSM states.
package commit_trace_buf_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] FINISH_ADDR_DEF = 32'h1000_0000;

  // Bit positions inside trace_rec_t.kind
  localparam int unsigned TRC_KIND_RF  = 0;
  localparam int unsigned TRC_KIND_BR  = 1;
  localparam int unsigned TRC_KIND_ST  = 2;
  localparam int unsigned TRC_KIND_JMP = 3;

  typedef struct packed {
    logic [31:0]     stamp;
    logic [3:0]      kind;
    logic [XLEN-1:0] tag;
    logic [31:0]     instr;
    logic [4:0]      rd;
    logic [XLEN-1:0] rf_data;
    logic [XLEN-1:0] target_pc;
    logic            br_taken;
    logic            br_mispred;
    logic [XLEN-1:0] st_addr;
    logic [XLEN-1:0] st_data;
  } trace_rec_t;

  localparam int unsigned TRACE_REC_W = $bits(trace_rec_t);

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_DONE
  } trc_state_e;

endpackage

// File: rtl/commit_trace_buf_if.sv
// Valid/ready trace record port between the commit trace buffer and its sink.
interface commit_trace_buf_if;
  import commit_trace_buf_pkg::*;

  logic       valid;
  logic       ready;
  trace_rec_t rec;

  modport master (output valid, output rec, input  ready);
  modport slave  (input  valid, input  rec, output ready);

endinterface

// File: rtl/commit_trace_buf_fifo.sv
// Synchronous FIFO with registered write and fall-through read; extra pointer
// MSB distinguishes full from empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_rd;
  logic             do_wr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd = pop & ~empty;
  // When full, a same-cycle pop frees the slot the write lands in.
  assign do_wr = push & (~full | do_rd);

  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/commit_trace_buf.sv
// Packs per-cycle EXU/LSU commit events into timestamped records, buffers them
// and drains them over a valid/ready port; tracks drops and the finish store.
module commit_trace_buf
  import commit_trace_buf_pkg::*;
#(
  parameter int unsigned     DEPTH       = 16,
  parameter logic [XLEN-1:0] FINISH_ADDR = FINISH_ADDR_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rf_wr_en,
  input  logic [4:0]      rf_rd_addr,
  input  logic [XLEN-1:0] rf_wr_data,
  input  logic [XLEN-1:0] instr_tag,
  input  logic [31:0]     instr,
  input  logic            pc_load,
  input  logic [XLEN-1:0] target_pc,
  input  logic            br_valid,
  input  logic            br_taken,
  input  logic            br_mispred,
  input  logic            st_valid,
  input  logic [XLEN-1:0] st_addr,
  input  logic [XLEN-1:0] st_data,
  commit_trace_buf_if.master trc,
  output logic            overflow,
  output logic [15:0]     drop_cnt,
  output logic            trace_done
);

  trc_state_e             state;
  trc_state_e             state_nxt;
  logic [31:0]            stamp;
  trace_rec_t             rec_in;
  logic [TRACE_REC_W-1:0] rd_bits;
  logic                   push_req;
  logic                   pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   drop;
  logic                   finish_hit;

  assign push_req   = (rf_wr_en | br_valid | st_valid | pc_load) & (state != S_DONE);
  assign pop        = trc.valid & trc.ready;
  assign drop       = push_req & fifo_full & ~pop;
  assign finish_hit = push_req & st_valid & (st_addr == FINISH_ADDR);

  always_comb begin
    rec_in                   = '0;
    rec_in.stamp             = stamp;
    rec_in.tag               = instr_tag;
    rec_in.instr             = instr;
    rec_in.kind[TRC_KIND_RF]  = rf_wr_en;
    rec_in.kind[TRC_KIND_BR]  = br_valid;
    rec_in.kind[TRC_KIND_ST]  = st_valid;
    rec_in.kind[TRC_KIND_JMP] = pc_load;
    if (rf_wr_en) begin
      rec_in.rd      = rf_rd_addr;
      rec_in.rf_data = rf_wr_data;
    end
    if (pc_load) rec_in.target_pc = target_pc;
    if (br_valid) begin
      rec_in.br_taken   = br_taken;
      rec_in.br_mispred = br_mispred;
    end
    if (st_valid) begin
      rec_in.st_addr = st_addr;
      rec_in.st_data = st_data;
    end
  end

  sync_fifo #(
    .WIDTH (TRACE_REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_req),
    .pop     (pop),
    .wr_data (rec_in),
    .rd_data (rd_bits),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign trc.valid = ~fifo_empty;
  assign trc.rec   = trace_rec_t'(rd_bits);

  always_ff @(posedge clk) begin
    if (rst) begin
      stamp    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
      state    <= S_RUN;
    end else begin
      stamp <= stamp + 1'b1;
      state <= state_nxt;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

  // Leaving DRAIN waits for a cycle with nothing buffered and nothing arriving.
  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN:   if (finish_hit) state_nxt = S_DRAIN;
      S_DRAIN: if (fifo_empty && !push_req) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_DONE;
      default: state_nxt = S_RUN;
    endcase
  end

  assign trace_done = (state == S_DONE);

endmodule

// File: tb/tb_commit_trace_buf.sv
// Directed testbench for commit_trace_buf: capture, merge, overflow, full
// push/pop, finish drain and mid-run reset.
module tb_commit_trace_buf;
  import commit_trace_buf_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rf_wr_en = 1'b0;
  logic [4:0]  rf_rd_addr = '0;
  logic [31:0] rf_wr_data = '0;
  logic [31:0] instr_tag = '0;
  logic [31:0] instr = '0;
  logic        pc_load = 1'b0;
  logic [31:0] target_pc = '0;
  logic        br_valid = 1'b0;
  logic        br_taken = 1'b0;
  logic        br_mispred = 1'b0;
  logic        st_valid = 1'b0;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic        overflow;
  logic [15:0] drop_cnt;
  logic        trace_done;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;
  int          cyc    = 0;

  commit_trace_buf_if trc_if();

  commit_trace_buf #(
    .DEPTH       (16),
    .FINISH_ADDR (32'h1000_0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rf_wr_en   (rf_wr_en),
    .rf_rd_addr (rf_rd_addr),
    .rf_wr_data (rf_wr_data),
    .instr_tag  (instr_tag),
    .instr      (instr),
    .pc_load    (pc_load),
    .target_pc  (target_pc),
    .br_valid   (br_valid),
    .br_taken   (br_taken),
    .br_mispred (br_mispred),
    .st_valid   (st_valid),
    .st_addr    (st_addr),
    .st_data    (st_data),
    .trc        (trc_if),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt),
    .trace_done (trace_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Drives one commit cycle and returns the record the bench expects for it.
  task automatic do_event(input logic rf, input logic [4:0] rd, input logic [31:0] data,
                          input logic jmp, input logic [31:0] tgt,
                          input logic brv, input logic tk, input logic mp,
                          input logic stv, input logic [31:0] sa, input logic [31:0] sd,
                          output trace_rec_t e);
    e = '0;
    e.stamp = cyc;
    e.kind  = {jmp, stv, brv, rf};
    e.tag   = 32'h8000_0000 + cyc * 4;
    e.instr = 32'h0000_0013 ^ cyc;
    if (rf)  begin e.rd = rd; e.rf_data = data; end
    if (jmp) e.target_pc = tgt;
    if (brv) begin e.br_taken = tk; e.br_mispred = mp; end
    if (stv) begin e.st_addr = sa; e.st_data = sd; end
    rf_wr_en = rf; rf_rd_addr = rd; rf_wr_data = data;
    pc_load = jmp; target_pc = tgt;
    br_valid = brv; br_taken = tk; br_mispred = mp;
    st_valid = stv; st_addr = sa; st_data = sd;
    instr_tag = e.tag; instr = e.instr;
    step();
    rf_wr_en = 0; rf_rd_addr = '0; rf_wr_data = '0; pc_load = 0; target_pc = '0;
    br_valid = 0; br_taken = 0; br_mispred = 0; st_valid = 0; st_addr = '0; st_data = '0;
    instr_tag = '0; instr = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    trc_if.ready = 1'b0;
    repeat (3) step();
    n_cmp++; if (trc_if.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", trc_if.valid); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    n_cmp++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt); end
    n_cmp++; if (trace_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", trace_done); end
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_single_rf();
    trace_rec_t e;
    trc_if.ready = 1'b1;
    repeat (3) step();
    do_event(1, 5'd5, 32'hDEAD_BEEF, 0, '0, 0, 0, 0, 0, '0, '0, e);
    n_cmp++; if (trc_if.valid !== 1'b1) begin n_fail++; $display("FAIL rf_valid: got %b want 1", trc_if.valid); end
    n_cmp++; if (trc_if.rec.stamp !== 32'd3) begin n_fail++; $display("FAIL rf_stamp: got %0d want 3", trc_if.rec.stamp); end
    n_cmp++; if (trc_if.rec.kind !== 4'b0001) begin n_fail++; $display("FAIL rf_kind: got %b want 0001", trc_if.rec.kind); end
    n_cmp++; if (trc_if.rec.rd !== 5'd5) begin n_fail++; $display("FAIL rf_rd: got %0d want 5", trc_if.rec.rd); end
    n_cmp++; if (trc_if.rec.rf_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rf_data: got %h want deadbeef", trc_if.rec.rf_data); end
    n_cmp++; if (trc_if.rec !== e) begin n_fail++; $display("FAIL rf_rec: got %h want %h", trc_if.rec, e); end
    step();
    n_cmp++; if (trc_if.valid !== 1'b0) begin n_fail++; $display("FAIL rf_popped: got %b want 0", trc_if.valid); end
  endtask

  task automatic test_merge();
    trace_rec_t e;
    trc_if.ready = 1'b0;
    do_event(1, 5'd10, 32'h1234_5678, 1, 32'h0000_2000, 1, 1, 1, 0, '0, '0, e);
    n_cmp++; if (trc_if.valid !== 1'b1) begin n_fail++; $display("FAIL merge_valid: got %b want 1", trc_if.valid); end
    n_cmp++; if (trc_if.rec.kind !== 4'b1011) begin n_fail++; $display("FAIL merge_kind: got %b want 1011", trc_if.rec.kind); end
    n_cmp++; if (trc_if.rec.target_pc !== 32'h0000_2000) begin n_fail++; $display("FAIL merge_target: got %h want 00002000", trc_if.rec.target_pc); end
    n_cmp++; if (trc_if.rec !== e) begin n_fail++; $display("FAIL merge_rec: got %h want %h", trc_if.rec, e); end
    trc_if.ready = 1'b1;
    step();
    n_cmp++; if (trc_if.valid !== 1'b0) begin n_fail++; $display("FAIL merge_single: got %b want 0", trc_if.valid); end
    trc_if.ready = 1'b0;
  endtask

  task automatic test_overflow();
    trace_rec_t e;
    trace_rec_t exp_r [16];
    trc_if.ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      do_event(1, i[4:0], 32'h100 + i, 0, '0, 0, 0, 0, 0, '0, '0, e);
      if (i < 16) exp_r[i] = e;
    end
    n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    n_cmp++; if (drop_cnt !== 16'd4) begin n_fail++; $display("FAIL ovf_drop_cnt: got %0d want 4", drop_cnt); end
    trc_if.ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      n_cmp++; if (trc_if.valid !== 1'b1 || trc_if.rec !== exp_r[k]) begin
        n_fail++; $display("FAIL ovf_order[%0d]: got v=%b %h want %h", k, trc_if.valid, trc_if.rec, exp_r[k]);
      end
      step();
    end
    n_cmp++; if (trc_if.valid !== 1'b0) begin n_fail++; $display("FAIL ovf_empty: got %b want 0", trc_if.valid); end
    trc_if.ready = 1'b0;
  endtask

  task automatic test_full_push_pop();
    trace_rec_t e;
    trace_rec_t exp_r [17];
    trc_if.ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      do_event(1, 5'd7, 32'h2000 + i, 0, '0, 0, 0, 0, 0, '0, '0, e);
      exp_r[i] = e;
    end
    n_cmp++; if (drop_cnt !== 16'd4) begin n_fail++; $display("FAIL full_fill_drop: got %0d want 4", drop_cnt); end
    trc_if.ready = 1'b1;
    do_event(0, '0, '0, 1, 32'h0000_4444, 0, 0, 0, 0, '0, '0, e);
    exp_r[16] = e;
    n_cmp++; if (drop_cnt !== 16'd4) begin n_fail++; $display("FAIL full_pp_drop: got %0d want 4", drop_cnt); end
    n_cmp++; if (trc_if.rec !== exp_r[1]) begin n_fail++; $display("FAIL full_pp_head: got %h want %h", trc_if.rec, exp_r[1]); end
    trc_if.ready = 1'b0;
    do_event(1, 5'd9, 32'h9999, 0, '0, 0, 0, 0, 0, '0, '0, e);
    n_cmp++; if (drop_cnt !== 16'd5) begin n_fail++; $display("FAIL full_still_full: got %0d want 5", drop_cnt); end
    trc_if.ready = 1'b1;
    for (int k = 1; k < 17; k++) begin
      n_cmp++; if (trc_if.valid !== 1'b1 || trc_if.rec !== exp_r[k]) begin
        n_fail++; $display("FAIL full_order[%0d]: got v=%b %h want %h", k, trc_if.valid, trc_if.rec, exp_r[k]);
      end
      step();
    end
    n_cmp++; if (trc_if.valid !== 1'b0) begin n_fail++; $display("FAIL full_empty: got %b want 0", trc_if.valid); end
    trc_if.ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    trace_rec_t e;
    trc_if.ready = 1'b0;
    for (int i = 0; i < 5; i++) do_event(1, 5'd3, 32'h3000 + i, 0, '0, 0, 0, 0, 0, '0, '0, e);
    n_cmp++; if (trc_if.valid !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_valid: got %b want 1", trc_if.valid); end
    rst = 1'b1;
    step();
    n_cmp++; if (trc_if.valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b want 0", trc_if.valid); end
    n_cmp++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL rmid_drop_cnt: got %0d want 0", drop_cnt); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rmid_overflow: got %b want 0", overflow); end
    rst = 1'b0;
    cyc = 0;
    do_event(1, 5'd1, 32'h0000_0042, 0, '0, 0, 0, 0, 0, '0, '0, e);
    n_cmp++; if (trc_if.rec.stamp !== 32'd0) begin n_fail++; $display("FAIL rmid_stamp: got %0d want 0", trc_if.rec.stamp); end
    n_cmp++; if (trc_if.rec !== e) begin n_fail++; $display("FAIL rmid_rec: got %h want %h", trc_if.rec, e); end
    trc_if.ready = 1'b1;
    step();
    trc_if.ready = 1'b0;
  endtask

  task automatic test_finish();
    trace_rec_t e;
    trace_rec_t exp_r [4];
    int n;
    logic popping;
    trc_if.ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      do_event(1, 5'd12, 32'h5000 + i, 0, '0, 0, 0, 0, 0, '0, '0, e);
      exp_r[i] = e;
    end
    do_event(0, '0, '0, 0, '0, 0, 0, 0, 1, 32'h1000_0000, 32'h0000_CAFE, e);
    exp_r[3] = e;
    n_cmp++; if (trace_done !== 1'b0) begin n_fail++; $display("FAIL fin_early_done: got %b want 0", trace_done); end
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      trc_if.ready = c[0];
      if (trc_if.valid === 1'b1) begin
        n_cmp++; if (trc_if.rec !== exp_r[n]) begin n_fail++; $display("FAIL fin_rec[%0d]: got %h want %h", n, trc_if.rec, exp_r[n]); end
      end
      popping = trc_if.valid & trc_if.ready;
      step();
      if (popping) n++;
    end
    n_cmp++; if (n !== 4) begin n_fail++; $display("FAIL fin_count: got %0d want 4", n); end
    trc_if.ready = 1'b1;
    n_cmp++; if (trc_if.valid !== 1'b0 || trace_done !== 1'b0) begin
      n_fail++; $display("FAIL fin_after_pop: got valid=%b done=%b want 0 0", trc_if.valid, trace_done);
    end
    step();
    n_cmp++; if (trace_done !== 1'b1) begin n_fail++; $display("FAIL fin_done: got %b want 1", trace_done); end
    for (int i = 0; i < 3; i++) begin
      do_event(1, 5'd2, 32'h7000 + i, 0, '0, 0, 0, 0, 1, 32'h20, 32'h1, e);
      n_cmp++; if (trc_if.valid !== 1'b0) begin n_fail++; $display("FAIL fin_ignored[%0d]: got %b want 0", i, trc_if.valid); end
    end
    n_cmp++; if (trace_done !== 1'b1) begin n_fail++; $display("FAIL fin_sticky: got %b want 1", trace_done); end
  endtask

  initial begin
    trc_if.ready = 1'b0;
    test_reset();
    test_single_rf();
    test_merge();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    test_finish();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within 200000 time units");
    $fatal(1);
  end

endmodule
